// File: rtl/washer_plant_model.sv
// washer_plant_model: drum plant (level, detergent, wash/spin timers); WM_PLANT_FAULT_EN builds the sticky misuse flag.
module washer_plant_model #(
  parameter int LEVEL_W     = 8,
  parameter int MAX_LEVEL   = 200,
  parameter int FULL_LEVEL  = 40,
  parameter int FILL_RATE   = 4,
  parameter int DRAIN_RATE  = 8,
  parameter int SOAP_DELAY  = 3,
  parameter int WASH_CYCLES = 5,
  parameter int SPIN_CYCLES = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               door_lock,
  input  logic               fill_value_on,
  input  logic               drain_value_on,
  input  logic               motor_on,
  input  logic               soap_wash,
  input  logic               water_wash,
  output logic               filled,
  output logic               drained,
  output logic               detergent_added,
  output logic               cycle_timeout,
  output logic               spin_timeout,
  output logic [LEVEL_W-1:0] level,
  output logic               fault
);
  typedef enum logic [2:0] {IDLE, WASH, WASH_DONE, SPIN, SPIN_DONE} state_t;
  localparam int CNT_W = $clog2(WASH_CYCLES + SPIN_CYCLES + 1);
  localparam int SOAP_W = $clog2(SOAP_DELAY + 2);
  localparam logic [LEVEL_W:0] FILL_INC = (LEVEL_W+1)'(FILL_RATE);
  localparam logic [LEVEL_W:0] DRAIN_DEC = (LEVEL_W+1)'(DRAIN_RATE);
  localparam logic [LEVEL_W:0] MAX_W = (LEVEL_W+1)'(MAX_LEVEL);
  localparam logic [LEVEL_W-1:0] MAX_V = LEVEL_W'(MAX_LEVEL);
  localparam logic [LEVEL_W-1:0] FULL_V = LEVEL_W'(FULL_LEVEL);
  localparam logic [CNT_W-1:0] WASH_LAST = CNT_W'(WASH_CYCLES - 1);
  localparam logic [CNT_W-1:0] SPIN_LAST = CNT_W'(SPIN_CYCLES - 1);
  localparam logic [SOAP_W-1:0] SOAP_MAX = SOAP_W'(SOAP_DELAY);
  localparam logic [SOAP_W-1:0] SOAP_LAST = SOAP_W'(SOAP_DELAY - 1);
  state_t state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [SOAP_W-1:0] soap_cnt;
  logic [LEVEL_W:0] up, dn;
  logic [LEVEL_W-1:0] level_nxt;
  logic soap_go, unused_in;
  assign filled = level >= FULL_V;
  assign drained = level == '0;
  assign cycle_timeout = state == WASH_DONE;
  assign spin_timeout = state == SPIN_DONE;
  assign soap_go = soap_wash & filled;
  // a borrow out of the extra top bit means the drain would go below empty
  always_comb begin
    up = {1'b0, level} + FILL_INC;
    dn = {1'b0, level} - DRAIN_DEC;
    level_nxt = (fill_value_on & ~drain_value_on) ? (up > MAX_W ? MAX_V : up[LEVEL_W-1:0]) :
                (drain_value_on & ~fill_value_on) ? (dn[LEVEL_W] ? '0 : dn[LEVEL_W-1:0]) : level;
  end
  always_comb begin
    state_nxt = state;
    cnt_nxt = cnt + 1'b1;
    if (state != IDLE && !motor_on) begin
      state_nxt = IDLE;
      cnt_nxt = '0;
    end else begin
      case (state)
        IDLE: begin
          cnt_nxt = '0;
          state_nxt = (motor_on & filled & ~drain_value_on) ? WASH : (motor_on & drained) ? SPIN : IDLE;
        end
        WASH: if (cnt == WASH_LAST) begin
          state_nxt = WASH_DONE;
          cnt_nxt = '0;
        end
        WASH_DONE: begin
          cnt_nxt = '0;
          state_nxt = drained ? SPIN : WASH_DONE;
        end
        SPIN: if (cnt == SPIN_LAST) begin
          state_nxt = SPIN_DONE;
          cnt_nxt = '0;
        end
        default: cnt_nxt = '0;
      endcase
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      level <= '0;
      soap_cnt <= '0;
      detergent_added <= 1'b0;
      state <= IDLE;
      cnt <= '0;
    end else begin
      level <= level_nxt;
      soap_cnt <= soap_go ? (soap_cnt == SOAP_MAX ? soap_cnt : soap_cnt + 1'b1) : '0;
      detergent_added <= (level_nxt == '0) ? 1'b0 : (soap_go && soap_cnt >= SOAP_LAST) ? 1'b1 : detergent_added;
      state <= state_nxt;
      cnt <= cnt_nxt;
    end
  end
`ifdef WM_PLANT_FAULT_EN
  assign unused_in = water_wash;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) fault <= 1'b0;
    else fault <= fault | (fill_value_on & drain_value_on) | (motor_on & ~door_lock) |
                  (fill_value_on & (level == MAX_V)) | (motor_on & ~filled & ~drained & (state == IDLE));
  end
`else
  assign unused_in = water_wash ^ door_lock;
  assign fault = 1'b0;
`endif
endmodule

// File: tb/tb_washer_plant_model.sv
// tb_washer_plant_model: directed checks of level, detergent, timers, fault and async reset.
module tb_washer_plant_model;
`ifdef WM_PLANT_FAULT_EN
  localparam logic FE = 1'b1;
`else
  localparam logic FE = 1'b0;
`endif
  logic clk = 0, reset = 1;
  logic door_lock = 0, fill_value_on = 0, drain_value_on = 0, motor_on = 0, soap_wash = 0, water_wash = 0;
  logic filled, drained, detergent_added, cycle_timeout, spin_timeout, fault;
  logic [7:0] level;
  int errors = 0, checks = 0;
  washer_plant_model dut (
    .clk(clk), .reset(reset), .door_lock(door_lock), .fill_value_on(fill_value_on),
    .drain_value_on(drain_value_on), .motor_on(motor_on), .soap_wash(soap_wash),
    .water_wash(water_wash), .filled(filled), .drained(drained),
    .detergent_added(detergent_added), .cycle_timeout(cycle_timeout),
    .spin_timeout(spin_timeout), .level(level), .fault(fault)
  );
  always #5 clk = ~clk;
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic check_reset_state(input string tag);
    check({tag, "_level"}, level, 0);
    check({tag, "_drained"}, drained, 1);
    check({tag, "_filled"}, filled, 0);
    check({tag, "_det"}, detergent_added, 0);
    check({tag, "_ct"}, cycle_timeout, 0);
    check({tag, "_st"}, spin_timeout, 0);
    check({tag, "_fault"}, fault, 0);
  endtask
  initial begin
    tick(2);
    check_reset_state("rst");
    reset = 0;
    door_lock = 1;
    fill_value_on = 1;
    tick(1);
    check("fill1_level", level, 4);
    check("fill1_drained", drained, 0);
    tick(8);
    check("fill9_level", level, 36);
    check("fill9_filled", filled, 0);
    tick(1);
    check("fill10_level", level, 40);
    check("fill10_filled", filled, 1);
    check("fill_nofault", fault, 0);
    fill_value_on = 0;
    soap_wash = 1;
    tick(2);
    check("soap2_det", detergent_added, 0);
    tick(1);
    check("soap3_det", detergent_added, 1);
    soap_wash = 0;
    motor_on = 1;
    tick(5);
    check("wash5_ct", cycle_timeout, 0);
    tick(1);
    check("wash6_ct", cycle_timeout, 1);
    motor_on = 0;
    tick(1);
    check("wash_off_ct", cycle_timeout, 0);
    drain_value_on = 1;
    tick(4);
    check("drain4_level", level, 8);
    check("drain4_det", detergent_added, 1);
    check("drain4_drained", drained, 0);
    tick(1);
    check("drain5_level", level, 0);
    check("drain5_drained", drained, 1);
    check("drain5_det", detergent_added, 0);
    drain_value_on = 0;
    motor_on = 1;
    tick(4);
    check("spin4_st", spin_timeout, 0);
    tick(1);
    check("spin5_st", spin_timeout, 1);
    motor_on = 0;
    tick(1);
    check("spin_off_st", spin_timeout, 0);
    fill_value_on = 1;
    tick(10);
    check("refill_level", level, 40);
    fill_value_on = 0;
    motor_on = 1;
    tick(6);
    check("w2s_ct", cycle_timeout, 1);
    drain_value_on = 1;
    tick(5);
    check("w2s_drained", drained, 1);
    check("w2s_hold_ct", cycle_timeout, 1);
    tick(1);
    check("w2s_ct_clear", cycle_timeout, 0);
    check("w2s_st0", spin_timeout, 0);
    tick(3);
    check("w2s_st3", spin_timeout, 0);
    tick(1);
    check("w2s_st4", spin_timeout, 1);
    motor_on = 0;
    drain_value_on = 0;
    tick(1);
    check("w2s_off_st", spin_timeout, 0);
    check("pre_both_fault", fault, 0);
    fill_value_on = 1;
    tick(2);
    check("pre_both_level", level, 8);
    drain_value_on = 1;
    tick(1);
    check("both_level", level, 8);
    check("both_fault", fault, FE);
    drain_value_on = 0;
    tick(48);
    check("sat_level", level, 200);
    tick(1);
    check("sat_hold_level", level, 200);
    check("sat_fault", fault, FE);
    fill_value_on = 0;
    drain_value_on = 1;
    tick(25);
    check("empty_level", level, 0);
    check("sticky_fault", fault, FE);
    drain_value_on = 0;
    fill_value_on = 1;
    tick(10);
    fill_value_on = 0;
    motor_on = 1;
    tick(2);
    drain_value_on = 1;
    tick(2);
    check("mid_level", level, 24);
    #3 reset = 1;
    motor_on = 0;
    drain_value_on = 0;
    #1;
    check_reset_state("async");
    #1 reset = 0;
    fill_value_on = 1;
    tick(10);
    check("restart_filled", filled, 1);
    fill_value_on = 0;
    motor_on = 1;
    tick(5);
    check("restart5_ct", cycle_timeout, 0);
    tick(1);
    check("restart6_ct", cycle_timeout, 1);
    check("restart_fault", fault, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
